vend_sequencer: RTL and testbench

- Transaction controller for the candy vending datapath.
- Accepts coin pulses and keypad events, holds the customer credit, and sequences two external resources over req/ack handshakes: the candy dispenser and the change hopper.
- Sits between the keypad/coin front end and the dispenser/hopper drivers. Publishes credit and per-slot affordability for the display.

---
 rtl/vend_pkg.sv | 24 ++
 rtl/vend_if.sv | 34 +++
 rtl/ack_timer.sv | 30 +++
 rtl/vend_sequencer.sv | 160 ++++++++++++++++
 tb/tb_vend_sequencer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the candy vending transaction controller.
package vend_pkg;
    typedef enum logic [1:0] {IDLE, DISPENSE, CHANGE, FAULT} state_e;

    localparam logic [3:0] COIN_100_U = 4'd1;
    localparam logic [3:0] COIN_500_U = 4'd5;
    localparam logic [3:0] PRICE0 = 4'd1;
    localparam logic [3:0] PRICE1 = 4'd2;
    localparam logic [3:0] PRICE2 = 4'd3;
    localparam logic [3:0] PRICE3 = 4'd4;
    localparam logic [3:0] PRICE4 = 4'd5;
    localparam int NUM_SLOTS = 5;

    function automatic logic [3:0] price_of(input logic [2:0] slot);
        case (slot)
            3'd0:    price_of = PRICE0;
            3'd1:    price_of = PRICE1;
            3'd2:    price_of = PRICE2;
            3'd3:    price_of = PRICE3;
            3'd4:    price_of = PRICE4;
            default: price_of = 4'd0;
        endcase
    endfunction
endpackage

// File: rtl/vend_if.sv
// Front-end, dispenser/hopper handshake and display signals of the vending controller.
interface vend_if;
    import vend_pkg::*;

    logic                 coin_100;
    logic                 coin_500;
    logic                 sel_valid;
    logic [2:0]           sel_slot;
    logic                 change_req;
    logic                 disp_req;
    logic [2:0]           disp_slot;
    logic                 disp_ack;
    logic                 chg_req;
    logic                 chg_coin;
    logic                 chg_ack;
    logic [3:0]           credit;
    logic [NUM_SLOTS-1:0] can_buy;
    logic                 busy;
    logic                 coin_reject;
    logic                 sel_err;
    logic                 fault;

    modport slave (
        input  coin_100, coin_500, sel_valid, sel_slot, change_req, disp_ack, chg_ack,
        output disp_req, disp_slot, chg_req, chg_coin, credit, can_buy, busy,
        output coin_reject, sel_err, fault
    );

    modport master (
        output coin_100, coin_500, sel_valid, sel_slot, change_req, disp_ack, chg_ack,
        input  disp_req, disp_slot, chg_req, chg_coin, credit, can_buy, busy,
        input  coin_reject, sel_err, fault
    );
endinterface

// File: rtl/ack_timer.sv
// Handshake watchdog: expired marks the ACK_TIMEOUT-th consecutive unacknowledged request cycle.
module ack_timer #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expired
);
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (run)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // cnt_q holds completed waiting cycles, so the current one is number cnt_q+1
    assign expired = run && !clear && (cnt_q == 8'(ACK_TIMEOUT - 1));
endmodule

// File: rtl/vend_sequencer.sv
// Vending transaction controller: credit keeping, dispense and greedy change payout sequencing.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255,
    parameter int MAX_CREDIT  = 15
) (
    input  logic clk,
    input  logic rst_n,
    vend_if.slave bus
);
    state_e     state_q, state_d;
    logic [3:0] credit_q, credit_d;
    logic       disp_req_q, disp_req_d;
    logic [2:0] disp_slot_q, disp_slot_d;
    logic       chg_req_q, chg_req_d;
    logic       chg_coin_q, chg_coin_d;
    logic       coin_reject_q, coin_reject_d;
    logic       sel_err_q, sel_err_d;
    logic       fault_q, fault_d;
    logic [4:0] run_credit;
    logic       sel_ok;
    logic       req_any, ack_any, expired;

    assign req_any = disp_req_q | chg_req_q;
    assign ack_any = (disp_req_q & bus.disp_ack) | (chg_req_q & bus.chg_ack);

    // Timer restarts from zero whenever no request is up, which covers the req rise
    ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!req_any || ack_any),
        .run     (req_any && !ack_any),
        .expired (expired)
    );

    assign sel_ok = (bus.sel_slot < 3'(NUM_SLOTS)) && (credit_q >= price_of(bus.sel_slot));

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        disp_req_d    = disp_req_q;
        disp_slot_d   = disp_slot_q;
        chg_req_d     = chg_req_q;
        chg_coin_d    = chg_coin_q;
        coin_reject_d = 1'b0;
        sel_err_d     = 1'b0;
        fault_d       = fault_q;
        run_credit    = {1'b0, credit_q};

        if (state_q != IDLE) begin
            coin_reject_d = bus.coin_100 | bus.coin_500;
            sel_err_d     = bus.sel_valid;
        end

        case (state_q)
            IDLE: begin
                // 500 is tried first so a 100 can still fit into the remaining headroom
                if (bus.coin_500) begin
                    if (run_credit + 5'(COIN_500_U) <= 5'(MAX_CREDIT))
                        run_credit = run_credit + 5'(COIN_500_U);
                    else
                        coin_reject_d = 1'b1;
                end
                if (bus.coin_100) begin
                    if (run_credit + 5'(COIN_100_U) <= 5'(MAX_CREDIT))
                        run_credit = run_credit + 5'(COIN_100_U);
                    else
                        coin_reject_d = 1'b1;
                end
                credit_d = run_credit[3:0];

                if (bus.sel_valid) begin
                    if (sel_ok) begin
                        credit_d    = run_credit[3:0] - price_of(bus.sel_slot);
                        disp_slot_d = bus.sel_slot;
                        disp_req_d  = 1'b1;
                        state_d     = DISPENSE;
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end else if (bus.change_req && credit_q != 4'd0) begin
                    chg_req_d  = 1'b1;
                    chg_coin_d = (run_credit >= 5'(COIN_500_U));
                    state_d    = CHANGE;
                end
            end

            DISPENSE: begin
                if (bus.disp_ack) begin
                    disp_req_d = 1'b0;
                    state_d    = IDLE;
                end else if (expired) begin
                    disp_req_d = 1'b0;
                    fault_d    = 1'b1;
                    state_d    = FAULT;
                end
            end

            CHANGE: begin
                if (chg_req_q) begin
                    if (bus.chg_ack) begin
                        credit_d  = credit_q - (chg_coin_q ? COIN_500_U : COIN_100_U);
                        chg_req_d = 1'b0;
                        if (credit_d == 4'd0)
                            state_d = IDLE;
                    end else if (expired) begin
                        chg_req_d = 1'b0;
                        fault_d   = 1'b1;
                        state_d   = FAULT;
                    end
                end else begin
                    // One idle cycle between coins, then request the next greedy coin
                    chg_req_d  = 1'b1;
                    chg_coin_d = (credit_q >= COIN_500_U);
                end
            end

            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            disp_req_q    <= 1'b0;
            disp_slot_q   <= '0;
            chg_req_q     <= 1'b0;
            chg_coin_q    <= 1'b0;
            coin_reject_q <= 1'b0;
            sel_err_q     <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            disp_req_q    <= disp_req_d;
            disp_slot_q   <= disp_slot_d;
            chg_req_q     <= chg_req_d;
            chg_coin_q    <= chg_coin_d;
            coin_reject_q <= coin_reject_d;
            sel_err_q     <= sel_err_d;
            fault_q       <= fault_d;
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_afford
        assign bus.can_buy[g] = (credit_q >= price_of(3'(g)));
    end

    assign bus.credit      = credit_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.disp_req    = disp_req_q;
    assign bus.disp_slot   = disp_slot_q;
    assign bus.chg_req     = chg_req_q;
    assign bus.chg_coin    = chg_coin_q;
    assign bus.coin_reject = coin_reject_q;
    assign bus.sel_err     = sel_err_q;
    assign bus.fault       = fault_q;
endmodule

// File: tb/tb_vend_sequencer.sv
// Scenario and randomized checks of vend_sequencer against a transaction-level credit model.
module tb_vend_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    vend_if bus ();
    vend_sequencer #(.ACK_TIMEOUT(8), .MAX_CREDIT(15)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    function automatic logic [4:0] exp_cb(input int c);
        logic [4:0] r;
        for (int i = 0; i < 5; i++) r[i] = (c >= i + 1);
        return r;
    endfunction

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic clr_in;
        bus.coin_100 = 0; bus.coin_500 = 0; bus.sel_valid = 0; bus.sel_slot = 0;
        bus.change_req = 0; bus.disp_ack = 0; bus.chg_ack = 0;
    endtask

    task automatic do_reset;
        clr_in();
        rst_n = 0; #12; rst_n = 1;
        tick();
    endtask

    task automatic test_reset;
        clr_in();
        rst_n = 0; #3;
        n_cmp++; if ({bus.disp_req, bus.chg_req, bus.chg_coin, bus.coin_reject, bus.sel_err, bus.fault, bus.busy} !== 7'b0) begin
            n_bad++; $display("FAIL reset_flags got %b want 0000000", {bus.disp_req, bus.chg_req, bus.chg_coin, bus.coin_reject, bus.sel_err, bus.fault, bus.busy}); end
        n_cmp++; if ({bus.credit, bus.can_buy, bus.disp_slot} !== 12'd0) begin
            n_bad++; $display("FAIL reset_data credit=%0d can_buy=%b slot=%0d want 0", bus.credit, bus.can_buy, bus.disp_slot); end
        #9; rst_n = 1;
        tick();
    endtask

    task automatic test_coins;
        bus.coin_500 = 1; tick(); clr_in();
        n_cmp++; if (bus.credit !== 4'd5) begin n_bad++; $display("FAIL coin_first credit got %0d want 5", bus.credit); end
        bus.coin_500 = 1; tick(); clr_in();
        n_cmp++; if (bus.credit !== 4'd10) begin n_bad++; $display("FAIL coin_second credit got %0d want 10", bus.credit); end
        n_cmp++; if ({bus.can_buy, bus.busy, bus.coin_reject} !== 7'b1111100) begin
            n_bad++; $display("FAIL coin_status can_buy=%b busy=%b rej=%b want 11111/0/0", bus.can_buy, bus.busy, bus.coin_reject); end
    endtask

    task automatic test_dispense;
        bus.sel_valid = 1; bus.sel_slot = 3'd4; tick(); clr_in();
        n_cmp++; if ({bus.credit, bus.disp_req, bus.disp_slot, bus.busy} !== {4'd5, 1'b1, 3'd4, 1'b1}) begin
            n_bad++; $display("FAIL disp_start credit=%0d req=%b slot=%0d busy=%b want 5/1/4/1", bus.credit, bus.disp_req, bus.disp_slot, bus.busy); end
        bus.sel_valid = 1; bus.sel_slot = 3'd1; bus.coin_500 = 1; tick(); clr_in();
        n_cmp++; if ({bus.sel_err, bus.coin_reject, bus.disp_slot, bus.credit} !== {1'b1, 1'b1, 3'd4, 4'd5}) begin
            n_bad++; $display("FAIL disp_busy_inputs err=%b rej=%b slot=%0d credit=%0d want 1/1/4/5", bus.sel_err, bus.coin_reject, bus.disp_slot, bus.credit); end
        tick();
        bus.disp_ack = 1; tick(); clr_in();
        n_cmp++; if ({bus.disp_req, bus.busy} !== 2'b00) begin
            n_bad++; $display("FAIL disp_done req=%b busy=%b want 0/0", bus.disp_req, bus.busy); end
    endtask

    task automatic test_change;
        int exp_cr[3] = '{2, 1, 0};
        logic exp_coin[3] = '{1'b1, 1'b0, 1'b0};
        bus.coin_100 = 1; tick(); tick(); clr_in();
        bus.change_req = 1; tick(); clr_in();
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if ({bus.chg_req, bus.chg_coin, bus.busy} !== {1'b1, exp_coin[k], 1'b1}) begin
                n_bad++; $display("FAIL chg_coin_%0d req=%b coin=%b busy=%b want 1/%b/1", k, bus.chg_req, bus.chg_coin, bus.busy, exp_coin[k]); end
            bus.chg_ack = 1; tick(); clr_in();
            n_cmp++; if ({bus.credit, bus.chg_req, bus.busy} !== {4'(exp_cr[k]), 1'b0, (k != 2)}) begin
                n_bad++; $display("FAIL chg_ack_%0d credit=%0d req=%b busy=%b want %0d/0/%b", k, bus.credit, bus.chg_req, bus.busy, exp_cr[k], k != 2); end
            if (k != 2) tick();
        end
    endtask

    task automatic test_overflow;
        do_reset();
        bus.coin_500 = 1; bus.coin_100 = 1; tick(); tick(); clr_in();
        bus.coin_100 = 1; tick(); tick(); clr_in();
        n_cmp++; if (bus.credit !== 4'd14) begin n_bad++; $display("FAIL ovf_setup credit got %0d want 14", bus.credit); end
        bus.coin_500 = 1; tick(); clr_in();
        n_cmp++; if ({bus.coin_reject, bus.credit} !== {1'b1, 4'd14}) begin
            n_bad++; $display("FAIL ovf_500 rej=%b credit=%0d want 1/14", bus.coin_reject, bus.credit); end
        bus.coin_100 = 1; tick(); clr_in();
        n_cmp++; if ({bus.coin_reject, bus.credit} !== {1'b0, 4'd15}) begin
            n_bad++; $display("FAIL ovf_100 rej=%b credit=%0d want 0/15", bus.coin_reject, bus.credit); end
        bus.coin_100 = 1; bus.coin_500 = 1; tick(); clr_in();
        n_cmp++; if ({bus.coin_reject, bus.credit} !== {1'b1, 4'd15}) begin
            n_bad++; $display("FAIL ovf_both rej=%b credit=%0d want 1/15", bus.coin_reject, bus.credit); end
    endtask

    task automatic test_sel_err;
        do_reset();
        bus.coin_100 = 1; tick(); tick(); clr_in();
        bus.sel_valid = 1; bus.sel_slot = 3'd3; tick(); clr_in();
        n_cmp++; if ({bus.sel_err, bus.credit, bus.busy} !== {1'b1, 4'd2, 1'b0}) begin
            n_bad++; $display("FAIL sel_poor err=%b credit=%0d busy=%b want 1/2/0", bus.sel_err, bus.credit, bus.busy); end
        tick();
        n_cmp++; if (bus.sel_err !== 1'b0) begin n_bad++; $display("FAIL sel_err_pulse got %b want 0", bus.sel_err); end
        bus.sel_valid = 1; bus.sel_slot = 3'd6; tick(); clr_in();
        n_cmp++; if ({bus.sel_err, bus.busy} !== 2'b10) begin
            n_bad++; $display("FAIL sel_badslot err=%b busy=%b want 1/0", bus.sel_err, bus.busy); end
    endtask

    task automatic test_timeout;
        int n = 0;
        do_reset();
        bus.coin_100 = 1; tick(); clr_in();
        bus.sel_valid = 1; bus.sel_slot = 3'd0; tick(); clr_in();
        while (bus.disp_req === 1'b1 && n < 40) begin tick(); n++; end
        n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL timeout_cycles got %0d want 8", n); end
        n_cmp++; if ({bus.fault, bus.busy} !== 2'b11) begin
            n_bad++; $display("FAIL timeout_fault fault=%b busy=%b want 1/1", bus.fault, bus.busy); end
        bus.coin_100 = 1; bus.sel_valid = 1; bus.sel_slot = 3'd0; tick(); clr_in();
        n_cmp++; if ({bus.coin_reject, bus.sel_err, bus.credit, bus.disp_req} !== {1'b1, 1'b1, 4'd0, 1'b0}) begin
            n_bad++; $display("FAIL fault_inputs rej=%b err=%b credit=%0d req=%b want 1/1/0/0", bus.coin_reject, bus.sel_err, bus.credit, bus.disp_req); end
    endtask

    task automatic test_async_reset;
        do_reset();
        bus.coin_100 = 1; tick(); tick(); tick(); clr_in();
        bus.change_req = 1; tick(); clr_in();
        n_cmp++; if (bus.chg_req !== 1'b1) begin n_bad++; $display("FAIL areset_setup chg_req got %b want 1", bus.chg_req); end
        #2; rst_n = 0; #1;
        n_cmp++; if ({bus.chg_req, bus.credit, bus.busy} !== 6'd0) begin
            n_bad++; $display("FAIL areset_mid_change req=%b credit=%0d busy=%b want 0/0/0", bus.chg_req, bus.credit, bus.busy); end
        #10; rst_n = 1;
        tick();
    endtask

    task automatic test_random;
        int mc, nc, pay;
        logic c5, c1, sv, cr, rej, acc, go;
        logic [2:0] sl;
        logic coins[$];
        do_reset();
        mc = 0;
        for (int it = 0; it < 150; it++) begin
            c5 = ($urandom_range(0, 3) == 0); c1 = ($urandom_range(0, 2) == 0);
            sv = ($urandom_range(0, 3) == 0); sl = 3'($urandom_range(0, 7));
            cr = ($urandom_range(0, 4) == 0);
            nc = mc; rej = 0;
            if (c5) begin if (nc + 5 <= 15) nc += 5; else rej = 1; end
            if (c1) begin if (nc + 1 <= 15) nc += 1; else rej = 1; end
            acc = sv && (sl <= 4) && (mc >= int'(sl) + 1);
            go  = !sv && cr && (mc > 0);
            if (acc) nc -= int'(sl) + 1;
            bus.coin_500 = c5; bus.coin_100 = c1; bus.sel_valid = sv; bus.sel_slot = sl; bus.change_req = cr;
            bus.disp_ack = 1'($urandom_range(0, 1)); bus.chg_ack = 1'($urandom_range(0, 1));
            tick(); clr_in();
            n_cmp++; if ({bus.credit, bus.coin_reject, bus.sel_err, bus.busy, bus.can_buy} !== {4'(nc), rej, sv && !acc, acc || go, exp_cb(nc)}) begin
                n_bad++; $display("FAIL rnd_idle_%0d credit=%0d rej=%b err=%b busy=%b cb=%b want %0d/%b/%b/%b/%b", it, bus.credit, bus.coin_reject,
                    bus.sel_err, bus.busy, bus.can_buy, nc, rej, sv && !acc, acc || go, exp_cb(nc)); end
            mc = nc;
            if (acc) begin
                n_cmp++; if ({bus.disp_req, bus.disp_slot} !== {1'b1, sl}) begin
                    n_bad++; $display("FAIL rnd_disp_%0d req=%b slot=%0d want 1/%0d", it, bus.disp_req, bus.disp_slot, sl); end
                repeat ($urandom_range(0, 4)) tick();
                bus.disp_ack = 1; tick(); clr_in();
                n_cmp++; if ({bus.disp_req, bus.busy, bus.credit} !== {1'b0, 1'b0, 4'(mc)}) begin
                    n_bad++; $display("FAIL rnd_disp_done_%0d req=%b busy=%b credit=%0d want 0/0/%0d", it, bus.disp_req, bus.busy, bus.credit, mc); end
            end
            if (go) begin
                coins.delete();
                pay = mc;
                while (pay > 0) begin
                    if (pay >= 5) begin coins.push_back(1'b1); pay -= 5; end
                    else begin coins.push_back(1'b0); pay -= 1; end
                end
                foreach (coins[k]) begin
                    n_cmp++; if ({bus.chg_req, bus.chg_coin} !== {1'b1, coins[k]}) begin
                        n_bad++; $display("FAIL rnd_chg_coin_%0d_%0d req=%b coin=%b want 1/%b", it, k, bus.chg_req, bus.chg_coin, coins[k]); end
                    repeat ($urandom_range(0, 3)) tick();
                    bus.chg_ack = 1; tick(); clr_in();
                    mc -= coins[k] ? 5 : 1;
                    n_cmp++; if ({bus.credit, bus.chg_req, bus.busy} !== {4'(mc), 1'b0, mc != 0}) begin
                        n_bad++; $display("FAIL rnd_chg_ack_%0d_%0d credit=%0d req=%b busy=%b want %0d/0/%b", it, k, bus.credit, bus.chg_req, bus.busy, mc, mc != 0); end
                    if (mc != 0) tick();
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_in();
        test_reset();
        test_coins();
        test_dispense();
        test_change();
        test_overflow();
        test_sel_err();
        test_timeout();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
